// File: rtl/mmio_uart_ctrl_if.sv
// ---------------------------------------------------------------------------
// mmio_uart_ctrl_if
//   Bundles the signals between the core, the MMIO UART controller and the
//   UART receiver/transmitter pair.
//
//   Core data bus   : addr, wdata, wbe, re (to controller), rdata (from it)
//   Core retire tag : inst_retire (to controller)
//   UART RX side    : rx_data, rx_valid (to controller), rx_ready (from it)
//   UART TX side    : tx_ready (to controller), tx_data, tx_valid (from it)
//
//   master : the side that drives the core bus and the UART handshakes
//            into the controller (core + UART blocks, or a testbench)
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface mmio_uart_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic        re;
  logic [31:0] rdata;
  logic        inst_retire;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output addr, wdata, wbe, re, inst_retire, rx_data, rx_valid, tx_ready,
    input  rdata, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  addr, wdata, wbe, re, inst_retire, rx_data, rx_valid, tx_ready,
    output rdata, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/mmio_uart_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_uart_ctrl
//   Memory-mapped I/O controller that sits beside dmem on the EX-stage data
//   bus. It decodes a 64-byte window at BASE_ADDR and returns read data one
//   cycle after the load, just like the synchronous data RAM. Between the
//   core and the UART blocks it keeps an RX FIFO and a TX FIFO, sticky
//   error flags, FIFO occupancy readout and cycle / retired-instruction
//   counters.
//
//   Register map (word offsets from BASE_ADDR):
//     0x00 STATUS  R/W1C  [0] TX not full  [1] RX not empty
//                         [2] tx_overflow  [3] rx_underflow
//     0x04 RX_DATA R      head byte, read pops
//     0x08 TX_DATA W      push wdata[7:0]
//     0x0C COUNT   R      [15:0] RX occupancy, [31:16] TX occupancy
//     0x10 CYCLE   R
//     0x14 INSTRET R
//     0x18 CNT_CLR W      any write zeroes both counters
//
//   Ports:
//     clk  : single clock, all state on the rising edge
//     rst  : asynchronous, active-low reset
//     bus  : mmio_uart_ctrl_if.slave (core bus, retire pulse, UART handshakes)
//
//   Parameters:
//     BASE_ADDR : window base, only bits [31:6] are compared
//     RX_DEPTH  : RX FIFO entries, power of two, 2..1024
//     TX_DEPTH  : TX FIFO entries, power of two, 2..1024
//     CNT_WIDTH : counter width, 1..32, zero-extended on read
// ---------------------------------------------------------------------------
module mmio_uart_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          CNT_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  mmio_uart_ctrl_if.slave bus
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);

  // Occupancy counters carry one extra bit so a full FIFO (== DEPTH) is
  // distinguishable from an empty one.
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

  localparam logic [3:0] REG_STATUS  = 4'h0;
  localparam logic [3:0] REG_RX_DATA = 4'h1;
  localparam logic [3:0] REG_TX_DATA = 4'h2;
  localparam logic [3:0] REG_COUNT   = 4'h3;
  localparam logic [3:0] REG_CYCLE   = 4'h4;
  localparam logic [3:0] REG_INSTRET = 4'h5;
  localparam logic [3:0] REG_CNT_CLR = 4'h6;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [7:0]           rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]     rx_wptr;
  logic [RX_AW-1:0]     rx_rptr;
  logic [RX_AW:0]       rx_count;

  logic [7:0]           tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]     tx_wptr;
  logic [TX_AW-1:0]     tx_rptr;
  logic [TX_AW:0]       tx_count;

  logic                 tx_overflow;
  logic                 rx_underflow;

  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;

  logic [31:0]          rdata_q;

  // -------------------------------------------------------------------------
  // Address decode and access qualifiers
  // -------------------------------------------------------------------------
  logic       in_window;
  logic [3:0] reg_idx;
  logic       wr_access;
  logic       rd_access;
  logic       unused_bits;

  assign in_window = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign reg_idx   = bus.addr[5:2];
  assign wr_access = in_window & (|bus.wbe);
  assign rd_access = in_window & bus.re;

  // Byte-offset bits and the upper store data are never looked at.
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

  // -------------------------------------------------------------------------
  // FIFO status and the push/pop decisions, all from pre-edge state
  // -------------------------------------------------------------------------
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_push, rx_pop_req, rx_pop, rx_underflow_set;
  logic tx_push_req, tx_push, tx_pop, tx_overflow_set;
  logic status_wr, clr_tx_overflow, clr_rx_underflow;
  logic cnt_clr;

  assign rx_full  = (rx_count == RX_FULL_CNT);
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == TX_FULL_CNT);
  assign tx_empty = (tx_count == '0);

  assign rx_push          = bus.rx_valid & ~rx_full;
  assign rx_pop_req       = rd_access & (reg_idx == REG_RX_DATA);
  assign rx_pop           = rx_pop_req & ~rx_empty;
  assign rx_underflow_set = rx_pop_req & rx_empty;

  // A write into a full TX FIFO is dropped even if the transmitter drains
  // an entry on the same edge: fullness is judged before the edge.
  assign tx_push_req     = wr_access & (reg_idx == REG_TX_DATA);
  assign tx_push         = tx_push_req & ~tx_full;
  assign tx_overflow_set = tx_push_req & tx_full;
  assign tx_pop          = ~tx_empty & bus.tx_ready;

  assign status_wr        = wr_access & (reg_idx == REG_STATUS) & bus.wbe[0];
  assign clr_tx_overflow  = status_wr & bus.wdata[2];
  assign clr_rx_underflow = status_wr & bus.wdata[3];

  assign cnt_clr = wr_access & (reg_idx == REG_CNT_CLR);

  // -------------------------------------------------------------------------
  // UART-side handshakes are combinational from the FIFO state
  // -------------------------------------------------------------------------
  assign bus.rx_ready = ~rx_full;
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_mem[tx_rptr];
  assign bus.rdata    = rdata_q;

  // -------------------------------------------------------------------------
  // Read mux; an empty RX FIFO reads as zero rather than stale storage
  // -------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (in_window) begin
      case (reg_idx)
        REG_STATUS:  rd_mux = {28'b0, rx_underflow, tx_overflow, ~rx_empty, ~tx_full};
        REG_RX_DATA: rd_mux = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rptr]};
        REG_COUNT:   rd_mux = {16'(tx_count), 16'(rx_count)};
        REG_CYCLE:   rd_mux = 32'(cycle_cnt);
        REG_INSTRET: rd_mux = 32'(instret_cnt);
        default:     rd_mux = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read data register: loads on any load cycle (zero outside the window),
  // otherwise holds so WB can treat it exactly like dmem output.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (bus.re) begin
      rdata_q <= rd_mux;
    end
  end

  // -------------------------------------------------------------------------
  // RX storage. Contents are never visible while empty, so no reset needed.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wptr] <= bus.rx_data;
    end
  end

  // -------------------------------------------------------------------------
  // RX pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_wptr <= rx_wptr + RX_AW'(1);
      end
      if (rx_pop) begin
        rx_rptr <= rx_rptr + RX_AW'(1);
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW + 1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // TX storage, pointers and occupancy. Storage is reset because the head
  // entry drives tx_data directly and must read 0 out of reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TX_DEPTH; i++) begin
        tx_mem[i] <= '0;
      end
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= bus.wdata[7:0];
        tx_wptr         <= tx_wptr + TX_AW'(1);
      end
      if (tx_pop) begin
        tx_rptr <= tx_rptr + TX_AW'(1);
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW + 1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW + 1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags; a set on the same edge as a W1C clear wins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= tx_overflow_set  | (tx_overflow  & ~clr_tx_overflow);
      rx_underflow <= rx_underflow_set | (rx_underflow & ~clr_rx_underflow);
    end
  end

  // -------------------------------------------------------------------------
  // Free-running cycle and retired-instruction counters. They wrap
  // naturally at 2^CNT_WIDTH; a clear suppresses that edge's increment.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt   <= cycle_cnt + CNT_WIDTH'(1);
      instret_cnt <= instret_cnt + CNT_WIDTH'(bus.inst_retire);
    end
  end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_ctrl
//   Directed testbench for mmio_uart_ctrl with RX/TX depth 8 and a 4-bit
//   counter so wrap-around is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_mmio_uart_ctrl;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = BASE + 32'h00;
  localparam logic [31:0] A_RX     = BASE + 32'h04;
  localparam logic [31:0] A_TX     = BASE + 32'h08;
  localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
  localparam logic [31:0] A_CYCLE  = BASE + 32'h10;
  localparam logic [31:0] A_INSTR  = BASE + 32'h14;
  localparam logic [31:0] A_CLR    = BASE + 32'h18;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] d;
  logic acc;

  mmio_uart_ctrl_if bus ();

  mmio_uart_ctrl #(
    .BASE_ADDR (BASE),
    .RX_DEPTH  (8),
    .TX_DEPTH  (8),
    .CNT_WIDTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single load: returns rdata sampled 1 time unit after the capturing edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
    bus.addr = a;
    bus.re   = 1'b1;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
    data   = bus.rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
    bus.addr  = a;
    bus.wdata = data;
    bus.wbe   = be;
    @(posedge clk);
    #1;
    bus.wbe = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected %h", bus.rdata, 32'h0); end
    vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b expected 1", bus.rx_ready); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", bus.tx_valid); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus_read(A_CYCLE, d);
    vectors++; if (d !== 32'd10) begin miscompares++; $display("[TB] FAIL idle_cycle: got %h expected %h", d, 32'd10); end
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL idle_status: got %h expected %h", d, 32'h1); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_tx_valid: got %b expected 0", bus.tx_valid); end
  endtask

  task automatic test_rx_fill();
    for (int i = 0; i < 8; i++) begin
      bus.rx_data  = 8'h10 + 8'(i);
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx_data = 8'h18;
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_full_ready: got %b expected 0", bus.rx_ready); end
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_held_off: got %b expected 0", bus.rx_ready); end
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0000_0008) begin miscompares++; $display("[TB] FAIL rx_count_full: got %h expected %h", d, 32'h8); end
    for (int i = 0; i < 8; i++) begin
      bus.addr = A_RX;
      bus.re   = 1'b1;
      acc      = bus.rx_valid & bus.rx_ready;
      @(posedge clk);
      #1;
      bus.re = 1'b0;
      if (acc) bus.rx_valid = 1'b0;
      vectors++; if (bus.rdata !== (32'h10 + 32'(i))) begin miscompares++; $display("[TB] FAIL rx_pop_%0d: got %h expected %h", i, bus.rdata, 32'h10 + 32'(i)); end
    end
    bus.rx_valid = 1'b0;
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL rx_count_after: got %h expected %h", d, 32'h1); end
    bus_read(A_RX, d);
    vectors++; if (d !== 32'h18) begin miscompares++; $display("[TB] FAIL rx_late_byte: got %h expected %h", d, 32'h18); end
  endtask

  task automatic test_rx_underflow();
    bus_read(A_RX, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL rx_empty_read: got %h expected %h", d, 32'h0); end
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h9) begin miscompares++; $display("[TB] FAIL underflow_set: got %h expected %h", d, 32'h9); end
    bus_write(A_STATUS, 32'h8, 4'b0001);
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL underflow_clr: got %h expected %h", d, 32'h1); end
    // push and pop together on an empty FIFO
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    bus_read(A_RX, d);
    bus.rx_valid = 1'b0;
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL empty_push_pop_rd: got %h expected %h", d, 32'h0); end
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'hB) begin miscompares++; $display("[TB] FAIL empty_push_pop_st: got %h expected %h", d, 32'hB); end
    bus_read(A_RX, d);
    vectors++; if (d !== 32'h5A) begin miscompares++; $display("[TB] FAIL empty_push_pop_data: got %h expected %h", d, 32'h5A); end
    bus_write(A_STATUS, 32'h8, 4'b0010);
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h9) begin miscompares++; $display("[TB] FAIL w1c_needs_wbe0: got %h expected %h", d, 32'h9); end
    bus_write(A_STATUS, 32'h8, 4'b0001);
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL underflow_clr2: got %h expected %h", d, 32'h1); end
  endtask

  task automatic test_tx_overflow();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus_write(A_TX, 32'h41 + 32'(i), 4'hF);
    end
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0008_0000) begin miscompares++; $display("[TB] FAIL tx_count_full: got %h expected %h", d, 32'h0008_0000); end
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h4) begin miscompares++; $display("[TB] FAIL tx_overflow_set: got %h expected %h", d, 32'h4); end
    vectors++; if (bus.tx_data !== 8'h41) begin miscompares++; $display("[TB] FAIL tx_head: got %h expected 41", bus.tx_data); end
    bus_write(A_STATUS, 32'h4, 4'b0001);
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL tx_overflow_clr: got %h expected %h", d, 32'h0); end
    // write while full with a pop on the same edge: the byte is dropped
    bus.tx_ready = 1'b1;
    bus_write(A_TX, 32'h4A, 4'hF);
    for (int i = 1; i < 8; i++) begin
      vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== (8'h41 + 8'(i))) begin miscompares++; $display("[TB] FAIL tx_drain_%0d: got %b/%h expected 1/%h", i, bus.tx_valid, bus.tx_data, 8'h41 + 8'(i)); end
      @(posedge clk);
      #1;
    end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_drained: got %b expected 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h5) begin miscompares++; $display("[TB] FAIL tx_full_pop_drop: got %h expected %h", d, 32'h5); end
    bus_write(A_STATUS, 32'h4, 4'b0001);
  endtask

  task automatic test_back_to_back();
    bus.tx_ready = 1'b1;
    bus.addr     = A_TX;
    bus.wbe      = 4'hF;
    bus.wdata    = 32'h61;
    @(posedge clk);
    #1;
    bus.wdata = 32'h62;
    @(posedge clk);
    #1;
    bus.wbe = 4'h0;
    vectors++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h62) begin miscompares++; $display("[TB] FAIL b2b_head: got %b/%h expected 1/62", bus.tx_valid, bus.tx_data); end
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0001_0000) begin miscompares++; $display("[TB] FAIL b2b_count: got %h expected %h", d, 32'h0001_0000); end
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_empty: got %b expected 0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_counters();
    bus_write(A_CLR, 32'h0, 4'hF);
    bus.inst_retire = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.inst_retire = 1'b0;
    bus_read(A_INSTR, d);
    vectors++; if (d !== 32'd4) begin miscompares++; $display("[TB] FAIL instret_wrap: got %h expected %h", d, 32'd4); end
    bus.inst_retire = 1'b1;
    bus_write(A_CLR, 32'h0, 4'hF);
    bus.inst_retire = 1'b0;
    bus_read(A_INSTR, d);
    vectors++; if (d !== 32'd0) begin miscompares++; $display("[TB] FAIL instret_clr_suppress: got %h expected %h", d, 32'd0); end
    bus_read(A_CYCLE, d);
    vectors++; if (d !== 32'd1) begin miscompares++; $display("[TB] FAIL cycle_after_clr: got %h expected %h", d, 32'd1); end
    bus_read(A_CYCLE, d);
    vectors++; if (d !== 32'd2) begin miscompares++; $display("[TB] FAIL cycle_step: got %h expected %h", d, 32'd2); end
    repeat (14) @(posedge clk);
    #1;
    bus_read(A_CYCLE, d);
    vectors++; if (d !== 32'd1) begin miscompares++; $display("[TB] FAIL cycle_wrap: got %h expected %h", d, 32'd1); end
  endtask

  task automatic test_decode();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (bus.rdata !== 32'd1) begin miscompares++; $display("[TB] FAIL rdata_hold: got %h expected %h", bus.rdata, 32'd1); end
    bus_read(BASE + 32'h3, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL low_bits_ignored: got %h expected %h", d, 32'h1); end
    bus_read(BASE + 32'h1C, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL unmapped_read: got %h expected %h", d, 32'h0); end
    bus_read(A_STATUS, d);
    bus_read(BASE + 32'h40, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL beyond_window: got %h expected %h", d, 32'h0); end
    bus_read(A_STATUS, d);
    bus_read(32'h9000_0000, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL outside_window: got %h expected %h", d, 32'h0); end
    bus_write(32'h9000_0008, 32'h77, 4'hF);
    vectors++; if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL outside_write: got %b expected 0", bus.tx_valid); end
  endtask

  task automatic test_async_reset();
    bus_read(A_RX, d);
    for (int i = 0; i < 4; i++) begin
      bus.rx_data  = 8'h20 + 8'(i);
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_write(A_TX, 32'h30 + 32'(i), 4'hF);
    end
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0004_0004) begin miscompares++; $display("[TB] FAIL half_full: got %h expected %h", d, 32'h0004_0004); end
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL async_rdata: got %h expected %h", bus.rdata, 32'h0); end
    vectors++; if (bus.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL async_rx_ready: got %b expected 1", bus.rx_ready); end
    vectors++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL async_tx: got %b/%h expected 0/00", bus.tx_valid, bus.tx_data); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_read(A_CYCLE, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL async_cycle: got %h expected %h", d, 32'h0); end
    bus_read(A_COUNT, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL async_count: got %h expected %h", d, 32'h0); end
    bus_read(A_STATUS, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("[TB] FAIL async_flags: got %h expected %h", d, 32'h1); end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    bus.addr        = 32'h0;
    bus.wdata       = 32'h0;
    bus.wbe         = 4'h0;
    bus.re          = 1'b0;
    bus.inst_retire = 1'b0;
    bus.rx_data     = 8'h0;
    bus.rx_valid    = 1'b0;
    bus.tx_ready    = 1'b0;
    rst             = 1'b1;

    test_reset();
    test_rx_fill();
    test_rx_underflow();
    test_tx_overflow();
    test_back_to_back();
    test_counters();
    test_decode();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_uart_ctrl.md
Name: mmio_uart_ctrl

Overview:
Memory-mapped I/O controller for the 3-stage RV32I core. It sits beside dmem on the EX-stage data bus and decodes the I/O address window. It returns read data with the same one-cycle latency as the synchronous data RAM, so WB muxes it the same way. It is the parametrised successor of the fixed UART/CSR I/O path: it adds depth-configurable RX/TX FIFOs between the core and the uart_receiver/uart_transmitter, sticky error flags, FIFO occupancy readout, and cycle/retired-instruction counters of configurable width.

Parameters:
BASE_ADDR, 32'h8000_0000, base of the 64-byte I/O window; addr[31:6] must equal BASE_ADDR[31:6].
RX_DEPTH, 8, RX FIFO entries; power of two, 2..1024.
TX_DEPTH, 8, TX FIFO entries; power of two, 2..1024.
CNT_WIDTH, 32, counter width, 1..32; the counter is zero-extended to 32 bits on read.

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-low reset; assertion clears all state immediately
addr  in  32  byte address from EX stage; word-aligned, bits [1:0] ignored
wdata  in  32  store data
wbe  in  4  byte write enables; any bit set = write access
re  in  1  load access this cycle
rdata  out  32  registered read data, valid the cycle after re
inst_retire  in  1  one instruction retired this cycle
rx_data  in  8  byte from uart_receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  RX FIFO can accept
tx_data  out  8  byte to uart_transmitter
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  transmitter accepts

Behaviour:
- Reset (rst=0, async): both FIFOs empty, pointers 0, counters 0, sticky flags 0, rdata=0, rx_ready=1, tx_valid=0, tx_data=0.
- Register map, as offsets from BASE_ADDR:
  - 0x00 STATUS R/W1C: [0]=TX not full, [1]=RX not empty, [2]=tx_overflow, [3]=rx_underflow. A write with wbe[0]=1 clears flag [2] and/or [3] wherever wdata[2]/wdata[3]=1.
  - 0x04 RX_DATA R: {24'b0, head byte}. The read pops the FIFO.
  - 0x08 TX_DATA W: the write pushes wdata[7:0].
  - 0x0C COUNT R: [15:0]=RX occupancy, [31:16]=TX occupancy.
  - 0x10 CYCLE R.
  - 0x14 INSTRET R.
  - 0x18 CNT_CLR W: any write zeroes both counters.
  - Other offsets in the window read 0; writes to them are ignored.
  - Outside the window: no effect, and rdata is 0 on the next cycle.
- Read latency: rdata is updated on the edge where re=1, using the pre-edge state. When re=0, rdata holds its previous value.
- RX path:
  - rx_ready = !rx_full (combinational).
  - A byte is pushed on an edge where rx_valid & rx_ready.
  - A full FIFO back-pressures the receiver and never loses data.
- RX read:
  - Non-empty: returns the head byte and pops on the same edge.
  - Empty: returns 0, does not pop, and sets rx_underflow.
  - Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
  - Simultaneous push and pop on an empty FIFO: the read returns 0, the push is accepted, and rx_underflow is set.
- TX path:
  - tx_valid = !tx_empty; tx_data = head byte (combinational from storage).
  - A byte is popped on an edge where tx_valid & tx_ready.
- TX write:
  - The full check uses the pre-edge state.
  - Write while full: the byte is dropped and tx_overflow is set, even if a pop happens on the same edge.
  - Push and pop on the same edge on a non-full FIFO: both succeed.
- Occupancy counters are log2(DEPTH)+1 bits wide, so full (== DEPTH) is distinguishable from empty. Pointers wrap modulo DEPTH.
- CYCLE:
  - Increments by 1 every cycle and wraps at 2^CNT_WIDTH to 0.
  - INSTRET increments when inst_retire=1, with the same wrap.
  - A CNT_CLR write sets both counters to 0 on that edge; that cycle's increment is suppressed.
  - A CYCLE read on the same edge as CNT_CLR returns the pre-clear value.
- Sticky flags: a set and a clear on the same edge → the set wins.
- re and wbe asserted together: both are serviced; the read sees the pre-write state.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high for 10 cycles, then read 0x10 → 10 (±pipeline offset fixed at 0 by read-before-edge rule); read 0x00 → 32'h1 (TX not full, RX empty); tx_valid=0.
- RX fill/back-pressure:
  - Stimulus: RX_DEPTH=8, drive bytes 0x10..0x18 with rx_valid held.
  - Response: after 8 accepts rx_ready=0 and 0x18 is held off.
  - Eight 0x04 reads return 0x10..0x17 in order; 0x18 is then accepted; COUNT[15:0]=1.
- RX underflow: read 0x04 while empty → rdata=0, STATUS[3]=1. Write 0x00 with wdata=8, wbe=1 → STATUS[3]=0.
- TX overflow and drain:
  - Stimulus: tx_ready=0, write 0x41..0x49 (9 bytes) to 0x08.
  - Response: COUNT[31:16]=8 and STATUS[2]=1.
  - Then raise tx_ready: tx_data sequence is 0x41..0x48, and tx_valid drops after 8 cycles.
- Counters:
  - Stimulus: CNT_WIDTH=4, inst_retire pulsed 20 times, then read 0x14.
  - Response: read returns 4 (wrap). A CNT_CLR write, then a CYCLE read two cycles later, returns 1.
- Async reset mid-transfer: assert rst between clock edges with both FIFOs half full → rdata, counts and flags are 0 immediately, before the next edge; rx_ready=1 and tx_valid=0.
